// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box tracker: FSM state encoding and the published box record.
package bbox_pkg;

  localparam int BOX_CW = 12;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    IN_FRAME = 2'd1,
    PUBLISH  = 2'd2
  } state_t;

  typedef struct packed {
    logic [BOX_CW-1:0] x_min;
    logic [BOX_CW-1:0] y_min;
    logic [BOX_CW-1:0] x_max;
    logic [BOX_CW-1:0] y_max;
  } box_t;

endpackage

// File: rtl/minmax_tracker.sv
// Running min/max of one coordinate axis. load seeds both bounds, update widens them,
// clear zeroes them. The next-state values are exported so a publish can include this beat.
module minmax_tracker #(
  parameter int CW = 12
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          clear,
  input  logic          load,
  input  logic          update,
  input  logic [CW-1:0] val,
  output logic [CW-1:0] lo_next,
  output logic [CW-1:0] hi_next
);

  logic [CW-1:0] lo;
  logic [CW-1:0] hi;

  always_comb begin
    lo_next = lo;
    hi_next = hi;
    if (load) begin
      lo_next = val;
      hi_next = val;
    end else if (clear) begin
      lo_next = '0;
      hi_next = '0;
    end else if (update) begin
      if (val < lo) lo_next = val;
      if (val > hi) hi_next = val;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      lo <= '0;
      hi <= '0;
    end else begin
      lo <= lo_next;
      hi <= hi_next;
    end
  end

endmodule

// File: rtl/bbox_tracker.sv
// Tracks the bounding box of dark pixels on a tapped video stream and publishes it once per frame.
//   state    | meaning
//   WAIT_SOF | idle, looking for a start-of-frame beat
//   IN_FRAME | scanning pixels, trackers live
//   PUBLISH  | box_valid cycle; a beat here is treated as in WAIT_SOF
import bbox_pkg::*;

module bbox_tracker #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    CW          = 12,
  parameter int                    FRAME_LINES = 480,
  parameter logic [DATA_WIDTH-1:0] THRESHOLD   = 8'h40
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic [CW-1:0]         x_min,
  output logic [CW-1:0]         y_min,
  output logic [CW-1:0]         x_max,
  output logic [CW-1:0]         y_max,
  output logic                  box_found,
  output logic                  box_valid,
  output logic                  sof_err
);

  localparam logic [CW-1:0] LAST_Y = CW'(FRAME_LINES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  state_t        state;
  box_t          pub;
  logic [CW-1:0] x, y, cur_x, cur_y, nx, ny;
  logic [CW-1:0] xlo_n, xhi_n, ylo_n, yhi_n;
  logic          found, found_next;
  logic          accept, hit, start, restart, fresh, in_pix, pix_hit, frame_end;
  logic          trk_clear, trk_load, trk_update;

  always_comb begin
    accept  = s_axis_tvalid && s_axis_tready;
    hit     = s_axis_tdata < THRESHOLD;
    start   = accept && s_axis_tuser && (state != IN_FRAME);
    // SOF at (0,0) inside a frame carries nothing to discard, so it is not an error
    restart = accept && s_axis_tuser && (state == IN_FRAME) && ((x != '0) || (y != '0));
    fresh   = start || restart;
    in_pix  = start || (accept && (state == IN_FRAME));
    pix_hit = in_pix && hit;
    cur_x   = fresh ? '0 : x;
    cur_y   = fresh ? '0 : y;

    trk_load   = pix_hit && (fresh || !found);
    trk_update = pix_hit && found && !fresh;
    trk_clear  = fresh && !hit;
    found_next = fresh ? hit : (found || pix_hit);
    frame_end  = in_pix && s_axis_tlast && (cur_y == LAST_Y);

    nx = sat_inc(cur_x);
    ny = cur_y;
    if (s_axis_tlast) begin
      nx = '0;
      ny = sat_inc(cur_y);
    end
  end

  minmax_tracker #(.CW(CW)) u_x_trk (
    .ACLK(ACLK), .ARESET(ARESET), .clear(trk_clear), .load(trk_load), .update(trk_update),
    .val(cur_x), .lo_next(xlo_n), .hi_next(xhi_n)
  );

  minmax_tracker #(.CW(CW)) u_y_trk (
    .ACLK(ACLK), .ARESET(ARESET), .clear(trk_clear), .load(trk_load), .update(trk_update),
    .val(cur_y), .lo_next(ylo_n), .hi_next(yhi_n)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= WAIT_SOF;
      x         <= '0;
      y         <= '0;
      found     <= 1'b0;
      pub       <= '0;
      box_found <= 1'b0;
      box_valid <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      box_valid <= 1'b0;
      sof_err   <= restart;
      if (in_pix) begin
        x     <= nx;
        y     <= ny;
        found <= found_next;
      end
      // Publish from the trackers' next values so the final beat's hit is included
      if (frame_end) begin
        state     <= PUBLISH;
        pub.x_min <= BOX_CW'(xlo_n);
        pub.y_min <= BOX_CW'(ylo_n);
        pub.x_max <= BOX_CW'(xhi_n);
        pub.y_max <= BOX_CW'(yhi_n);
        box_found <= found_next;
        box_valid <= 1'b1;
      end else if (fresh) begin
        state <= IN_FRAME;
      end else if (state == PUBLISH) begin
        state <= WAIT_SOF;
      end
    end
  end

  assign x_min = pub.x_min[CW-1:0];
  assign y_min = pub.y_min[CW-1:0];
  assign x_max = pub.x_max[CW-1:0];
  assign y_max = pub.y_max[CW-1:0];

endmodule
